// File: rtl/fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit_if : imem bus, redirect/stall control and decode-side outputs
// Revision 1.0
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [6:0]  OpCode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic        misalign_err;
  logic        bus_err;

  // master: the fetch unit itself
  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
           OpCode, Funct3, Funct7, misalign_err, bus_err,
    input  imem_ready, imem_rdata, redirect, redirect_pc, stall
  );

  // slave: instruction memory plus branch path and decode stage
  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid,
           OpCode, Funct3, Funct7, misalign_err, bus_err,
    output imem_ready, imem_rdata, redirect, redirect_pc, stall
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : RV32I fetch stage; PC, imem handshake, redirect, error flags
// Revision 1.0
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_ISSUED = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  localparam logic [31:0] C_NOP     = 32'h0000_0013;
  localparam logic [7:0]  C_TIMEOUT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= C_NOP;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    misalign_d   = misalign_q;
    bus_err_d    = bus_err_q;
    cnt_d        = cnt_q;

    // ERROR ignores redirects; elsewhere a redirect overrides handshake and stall
    if (state_q != S_ERROR && bus.redirect) begin
      inst_valid_d = 1'b0;
      cnt_d        = 8'd0;
      if (bus.redirect_pc[1:0] == 2'b00) begin
        pc_d    = bus.redirect_pc;
        state_d = S_FETCH;
      end else begin
        misalign_d = 1'b1;
        state_d    = S_ERROR;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ready) begin
            inst_d       = bus.imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            cnt_d        = 8'd0;
            state_d      = S_ISSUED;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d >= C_TIMEOUT) begin
              bus_err_d = 1'b1;
              state_d   = S_ERROR;
            end
          end
        end
        S_ISSUED: begin
          if (!bus.stall) begin
            inst_valid_d = 1'b0;
            state_d      = S_FETCH;
          end
        end
        default: begin
          inst_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Request is gated by reset so it drops the instant rst_n asserts
  assign bus.imem_req     = (state_q == S_FETCH) && rst_n;
  assign bus.imem_addr    = pc_q;
  assign bus.inst         = inst_q;
  assign bus.inst_pc      = inst_pc_q;
  assign bus.inst_valid   = inst_valid_q;
  assign bus.OpCode       = inst_q[6:0];
  assign bus.Funct3       = inst_q[14:12];
  assign bus.Funct7       = inst_q[31:25];
  assign bus.misalign_err = misalign_q;
  assign bus.bus_err      = bus_err_q;

endmodule
`default_nettype wire
